vx_warp_context: RTL

- Multi-warp, multi-thread register context for the decode stage: NUM_WARPS x NUM_THREADS register files, two read ports per thread, one writeback port per thread.
- Contains a sequential clone engine that copies thread 0's registers of a warp into a target thread, stalling the issuing instruction until the copy completes.
- Operand outputs apply the JAL-PC select and the forwarding muxes, feeding the execute stage.

---
 rtl/vx_warp_context_if.sv | 45 ++++
 rtl/vx_warp_context.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vx_warp_context_if.sv
// Decode-stage register context bus: read/writeback requests in, per-thread operands and clone status out.
interface vx_warp_context_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 2,
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RW = $clog2(NUM_REGS);
    localparam int VW = NUM_THREADS * DATA_WIDTH;

    logic [WW-1:0]          in_warp;
    logic [WW-1:0]          in_wb_warp;
    logic [NUM_THREADS-1:0] in_valid;
    logic                   in_write_register;
    logic [RW-1:0]          in_rd;
    logic [VW-1:0]          in_write_data;
    logic [RW-1:0]          in_src1;
    logic [RW-1:0]          in_src2;
    logic [DATA_WIDTH-1:0]  in_curr_PC;
    logic                   in_is_clone;
    logic                   in_is_jal;
    logic                   in_src1_fwd;
    logic                   in_src2_fwd;
    logic [VW-1:0]          in_src1_fwd_data;
    logic [VW-1:0]          in_src2_fwd_data;
    logic [VW-1:0]          out_a_reg_data;
    logic [VW-1:0]          out_b_reg_data;
    logic                   out_clone_stall;
    logic                   out_clone_busy;

    modport master (
        output in_warp, in_wb_warp, in_valid, in_write_register, in_rd, in_write_data,
               in_src1, in_src2, in_curr_PC, in_is_clone, in_is_jal,
               in_src1_fwd, in_src2_fwd, in_src1_fwd_data, in_src2_fwd_data,
        input  out_a_reg_data, out_b_reg_data, out_clone_stall, out_clone_busy
    );

    modport slave (
        input  in_warp, in_wb_warp, in_valid, in_write_register, in_rd, in_write_data,
               in_src1, in_src2, in_curr_PC, in_is_clone, in_is_jal,
               in_src1_fwd, in_src2_fwd, in_src1_fwd_data, in_src2_fwd_data,
        output out_a_reg_data, out_b_reg_data, out_clone_stall, out_clone_busy
    );
endinterface

// File: rtl/vx_warp_context.sv
// Warp register context: NUM_WARPS x NUM_THREADS register files, operand muxes and a thread-clone engine.
// Optional: define VX_CTX_WRITE_BYPASS_EN to return same-cycle writeback data on the read ports.

module vx_warp_context_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rd1,
    input  logic [DATA_WIDTH-1:0] i_rd2,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_fwd1,
    input  logic [DATA_WIDTH-1:0] i_fwd2,
    input  logic                  i_is_jal,
    input  logic                  i_src1_fwd,
    input  logic                  i_src2_fwd,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b
);
    // JAL takes precedence over forwarding so the link computation always sees the PC.
    assign o_a = i_is_jal ? i_pc : (i_src1_fwd ? i_fwd1 : i_rd1);
    assign o_b = i_src2_fwd ? i_fwd2 : i_rd2;
endmodule

module vx_warp_context #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 2,
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 32
) (
    input logic              clk,
    input logic              reset_n,
    vx_warp_context_if.slave bus
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RW = $clog2(NUM_REGS);
    localparam int TW = $clog2(NUM_THREADS);

    typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_DONE} state_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_WARPS][NUM_THREADS][NUM_REGS];

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_idx, w_idx_nxt;
    logic [WW-1:0] r_warp, w_warp_nxt;
    logic [TW-1:0] r_tgt, w_tgt_nxt;
    logic          w_copy_en;

    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] w_wdata, w_fwd1, w_fwd2;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] w_rd1, w_rd2, w_a, w_b;
    logic [NUM_THREADS-1:0]                 w_wr_en;

    logic [TW-1:0] w_tgt_cand;
    logic          w_tgt_ok;

    assign w_wdata = bus.in_write_data;
    assign w_fwd1  = bus.in_src1_fwd_data;
    assign w_fwd2  = bus.in_src2_fwd_data;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        logic w_byp1, w_byp2;

        assign w_wr_en[t] = bus.in_write_register && bus.in_valid[t] && (bus.in_rd != '0);

`ifdef VX_CTX_WRITE_BYPASS_EN
        assign w_byp1 = w_wr_en[t] && (bus.in_wb_warp == bus.in_warp) && (bus.in_rd == bus.in_src1);
        assign w_byp2 = w_wr_en[t] && (bus.in_wb_warp == bus.in_warp) && (bus.in_rd == bus.in_src2);
`else
        assign w_byp1 = 1'b0;
        assign w_byp2 = 1'b0;
`endif

        // x0 is hardwired; the write enable already excludes rd==0, so bypass can never leak into it.
        assign w_rd1[t] = (bus.in_src1 == '0) ? '0 :
                          w_byp1 ? w_wdata[t] : r_regs[bus.in_warp][t][bus.in_src1];
        assign w_rd2[t] = (bus.in_src2 == '0) ? '0 :
                          w_byp2 ? w_wdata[t] : r_regs[bus.in_warp][t][bus.in_src2];

        vx_warp_context_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .i_rd1      (w_rd1[t]),
            .i_rd2      (w_rd2[t]),
            .i_pc       (bus.in_curr_PC),
            .i_fwd1     (w_fwd1[t]),
            .i_fwd2     (w_fwd2[t]),
            .i_is_jal   (bus.in_is_jal),
            .i_src1_fwd (bus.in_src1_fwd),
            .i_src2_fwd (bus.in_src2_fwd),
            .o_a        (w_a[t]),
            .o_b        (w_b[t])
        );
    end

    assign bus.out_a_reg_data = w_a;
    assign bus.out_b_reg_data = w_b;

    // Clone target comes from thread 0's src1 operand; anything outside 1..NUM_THREADS-1 is a no-op clone.
    assign w_tgt_cand = w_rd1[0][TW-1:0];
    assign w_tgt_ok   = (w_rd1[0][DATA_WIDTH-1:TW] == '0) && (w_tgt_cand != '0) &&
                        (32'(w_tgt_cand) < NUM_THREADS);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_warp_nxt  = r_warp;
        w_tgt_nxt   = r_tgt;
        w_copy_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_is_clone) begin
                    w_warp_nxt = bus.in_warp;
                    w_tgt_nxt  = w_tgt_cand;
                    if (w_tgt_ok) begin
                        w_state_nxt = ST_COPY;
                        w_idx_nxt   = RW'(1);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_COPY: begin
                if (!bus.in_is_clone) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_copy_en = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == RW'(NUM_REGS - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_warp  <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_warp  <= w_warp_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Copy first, writeback second: a same-cycle writeback to the copy destination wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int t = 0; t < NUM_THREADS; t++)
                    for (int r = 0; r < NUM_REGS; r++)
                        r_regs[w][t][r] <= '0;
        end else begin
            if (w_copy_en)
                r_regs[r_warp][r_tgt][r_idx] <= r_regs[r_warp][0][r_idx];
            for (int t = 0; t < NUM_THREADS; t++)
                if (w_wr_en[t])
                    r_regs[bus.in_wb_warp][t][bus.in_rd] <= w_wdata[t];
        end
    end

    assign bus.out_clone_stall = reset_n && bus.in_is_clone && (r_state != ST_DONE);
    assign bus.out_clone_busy  = (r_state != ST_IDLE);

endmodule
